core_block_ctrl: RTL and testbench
==================================

// Module: core_block_ctrl
// PURPOSE
//  Core-side end of the block-dispatch handshake. Latches block_id/thread_count when the dispatcher raises start.
//  Sequences one block through FETCH->DECODE->REQUEST->WAIT->EXECUTE->UPDATE until RET, then holds done until the
//  dispatcher's core reset. Drives PC/instruction-memory handshake, per-thread enable mask and a busy-cycle counter.
// PARAMETERS
//  THREADS_PER_BLOCK  16  threads per core; TCW = $clog2(THREADS_PER_BLOCK)+1
//  PC_BITS            8   program-counter width
//  INSTR_BITS         16  instruction word width
// PORTS
//  clk            in   1                    clock
//  reset          in   1                    synchronous, active-high (driven by dispatcher core_reset)
//  start          in   1                    level; block assigned, sampled in IDLE only
//  block_id_in    in   8                    block index, latched on start
//  thread_count_in in  TCW                  active threads in block, latched on start
//  block_id       out  8                    latched block index
//  thread_enable  out  THREADS_PER_BLOCK    bit t = 1 iff t < latched thread count
//  imem_req       out  1                    instruction fetch request (registered)
//  imem_addr      out  PC_BITS              fetch address = pc
//  imem_ack       in   1                    fetch complete, imem_data valid this cycle
//  imem_data      in   INSTR_BITS           fetched instruction
//  instr          out  INSTR_BITS           captured instruction, to decoder
//  instr_valid    out  1                    1-cycle pulse in DECODE
//  is_ret         in   1                    decoder: instr is RET
//  mem_pending    in   THREADS_PER_BLOCK    per-thread LSU busy
//  next_pc        in   THREADS_PER_BLOCK*PC_BITS  flattened per-thread next PC, thread t at [t*PC_BITS +: PC_BITS]
//  pc             out  PC_BITS              current PC
//  core_state     out  3                    current state encoding
//  busy_cycles    out  16                   cycles spent outside IDLE/DONE, saturating
//  done           out  1                    block finished; stays 1 until reset
// BEHAVIOUR
//  - Reset (wins over start): state=IDLE; pc, block_id, thread_enable, instr, busy_cycles = 0; imem_req, instr_valid, done = 0.
//  - States: IDLE=0 FETCH=1 DECODE=2 REQUEST=3 WAIT=4 EXECUTE=5 UPDATE=6 DONE=7.
//  - IDLE: on start, latch block_id_in and clamp thread_count_in to THREADS_PER_BLOCK; pc<=0.
//    If count==0 -> DONE, imem_req never raised. Otherwise -> FETCH with imem_req<=1 on the same edge.
//  - FETCH: imem_req held at 1 until imem_ack. On ack: instr<=imem_data, imem_req<=0, -> DECODE.
//    imem_ack outside FETCH is ignored.
//  - DECODE: instr_valid=1 for exactly this cycle; -> REQUEST.
//  - REQUEST: 1 cycle; -> WAIT.
//  - WAIT: stay while |(mem_pending & thread_enable); else -> EXECUTE. Pending on disabled threads is ignored. Minimum 1 cycle.
//  - EXECUTE: 1 cycle; -> UPDATE.
//  - UPDATE: if is_ret -> DONE. Else pc <= next_pc of thread 0 (no divergence support), -> FETCH, imem_req<=1.
//  - DONE: done=1 (registered, equals state==DONE); start ignored; leaves only on reset.
//  - Zero-wait fetch (ack in first FETCH cycle) costs 6 cycles per instruction.
//    done is visible 7 edges after start is sampled for a single-RET program.
//  - busy_cycles increments every cycle in FETCH..UPDATE and saturates at 16'hFFFF.
//  - pc is not wrapped by this block; next_pc is trusted.
//  - Reset in any state: full return to IDLE on that edge; imem_req drops. A late ack after reset is ignored.
// STRUCTURE
//  - Package gpgpu_int8_pkg: core_state_t enum (values above), PC_BITS, INSTR_BITS, thread-count width function.
//  - Single module; no sub-module. thread_enable mask generation is an inline loop.
// TESTING
//  1. start, block_id_in=3, count=16, imem returns RET at pc0 with immediate ack
//     -> block_id=3, thread_enable=16'hFFFF, done=1 after edge 7, busy_cycles=6.
//  2. count=5 -> thread_enable=16'h001F. count=20 -> 16'hFFFF (clamp).
//     count=0 -> done=1 after edge 1, imem_req never asserted.
//  3. Program NOP,NOP,RET with next_pc=pc+1 and zero-wait ack
//     -> imem_addr sequence 0,1,2; 3 instr_valid pulses; done after edge 19.
//  4. Thread 2 enabled with mem_pending[2]=1 for 4 cycles -> WAIT lasts 5 cycles.
//     Thread 9 pending with count=5 -> WAIT lasts 1 cycle.
//  5. Ack delayed 3 cycles -> imem_req high 4 cycles, instr captured only on the ack cycle.
//  6. reset asserted in WAIT, then ack arrives in IDLE -> state=0, done=0, imem_req=0, ack ignored.
//     New start runs block normally.

Source files
------------

// File: rtl/gpgpu_int8_pkg.sv
// ----------------------------------------------------------------------------
// gpgpu_int8_pkg
//   Shared types and sizing for the core block controller.
//   - core_state_t : controller state encoding, also exported on core_state
//   - THREADS_PER_BLOCK, PC_BITS, INSTR_BITS, BLOCK_ID_BITS, BUSY_BITS
//   - tc_width()   : width of a thread count able to hold 0..THREADS_PER_BLOCK
// ----------------------------------------------------------------------------
package gpgpu_int8_pkg;

   localparam int THREADS_PER_BLOCK = 16;
   localparam int PC_BITS           = 8;
   localparam int INSTR_BITS        = 16;
   localparam int BLOCK_ID_BITS     = 8;
   localparam int BUSY_BITS         = 16;

   // One extra bit so a full block (count == THREADS_PER_BLOCK) is representable.
   function automatic int tc_width(input int threads);
      return $clog2(threads) + 1;
   endfunction

   localparam int TCW = tc_width(THREADS_PER_BLOCK);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_REQUEST = 3'd3,
      ST_WAIT    = 3'd4,
      ST_EXECUTE = 3'd5,
      ST_UPDATE  = 3'd6,
      ST_DONE    = 3'd7
   } core_state_t;

endpackage

// File: rtl/core_block_ctrl_if.sv
// ----------------------------------------------------------------------------
// core_block_ctrl_if
//   Instruction-memory fetch handshake between the core controller and imem.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : fetch address (current pc)
//   imem_ack   : fetch complete, imem_data valid in this cycle
//   imem_data  : fetched instruction word
//   modport master : controller side
//   modport slave  : memory side
// ----------------------------------------------------------------------------
interface core_block_ctrl_if;
   import gpgpu_int8_pkg::*;

   logic                  imem_req;
   logic [PC_BITS-1:0]    imem_addr;
   logic                  imem_ack;
   logic [INSTR_BITS-1:0] imem_data;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_data
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_data
   );

endinterface

// File: rtl/core_block_ctrl.sv
// ----------------------------------------------------------------------------
// core_block_ctrl
//   Core-side end of the block-dispatch handshake. Latches the block on start,
//   then steps one instruction at a time through
//   FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE until a RET retires,
//   after which done is held until the dispatcher resets the core.
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   start             : block assigned (level, only looked at in IDLE)
//   block_id_in       : block index, latched on start
//   thread_count_in   : active thread count, latched (clamped) on start
//   block_id          : latched block index
//   thread_enable     : bit t set iff t < latched thread count
//   imem              : instruction fetch handshake (master side)
//   instr/instr_valid : captured instruction and its one-cycle DECODE pulse
//   is_ret            : decoder flag, instruction is RET
//   mem_pending       : per-thread LSU busy
//   next_pc           : per-thread next pc, thread t at [t*PC_BITS +: PC_BITS]
//   pc, core_state    : current pc and state encoding
//   busy_cycles       : saturating count of cycles spent in FETCH..UPDATE
//   done              : block finished
// ----------------------------------------------------------------------------
module core_block_ctrl
   import gpgpu_int8_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic [BLOCK_ID_BITS-1:0]             block_id_in,
   input  logic [TCW-1:0]                       thread_count_in,
   output logic [BLOCK_ID_BITS-1:0]             block_id,
   output logic [THREADS_PER_BLOCK-1:0]         thread_enable,
   core_block_ctrl_if.master                    imem,
   output logic [INSTR_BITS-1:0]                instr,
   output logic                                 instr_valid,
   input  logic                                 is_ret,
   input  logic [THREADS_PER_BLOCK-1:0]         mem_pending,
   input  logic [THREADS_PER_BLOCK*PC_BITS-1:0] next_pc,
   output logic [PC_BITS-1:0]                   pc,
   output logic [2:0]                           core_state,
   output logic [BUSY_BITS-1:0]                 busy_cycles,
   output logic                                 done
);

   core_state_t                    state_r;
   core_state_t                    state_next_s;
   logic [BLOCK_ID_BITS-1:0]       block_id_r;
   logic [THREADS_PER_BLOCK-1:0]   thread_enable_r;
   logic [PC_BITS-1:0]             pc_r;
   logic [INSTR_BITS-1:0]          instr_r;
   logic                           instr_valid_r;
   logic                           imem_req_r;
   logic [BUSY_BITS-1:0]           busy_cycles_r;
   logic                           done_r;

   logic [TCW-1:0]                 count_clamped_s;
   logic [THREADS_PER_BLOCK-1:0]   enable_mask_s;
   logic                           wait_hold_s;
   logic                           busy_active_s;
   logic [PC_BITS-1:0]             next_pc_t0_s;
   logic                           unused_next_pc_s;

   // No divergence support: only thread 0's next pc is followed.
   assign next_pc_t0_s     = next_pc[PC_BITS-1:0];
   assign unused_next_pc_s = ^next_pc[THREADS_PER_BLOCK*PC_BITS-1:PC_BITS];

   // Pending loads on disabled threads must not stall the block.
   assign wait_hold_s   = |(mem_pending & thread_enable_r);
   assign busy_active_s = (state_r != ST_IDLE) && (state_r != ST_DONE);

   // Clamp the requested thread count and expand it into an enable mask.
   always_comb begin
      count_clamped_s = thread_count_in;
      enable_mask_s   = {THREADS_PER_BLOCK{1'b0}};
      if (thread_count_in > TCW'(THREADS_PER_BLOCK)) begin
         count_clamped_s = TCW'(THREADS_PER_BLOCK);
      end else begin
         count_clamped_s = thread_count_in;
      end
      for (int t = 0; t < THREADS_PER_BLOCK; t++) begin
         enable_mask_s[t] = (TCW'(t) < count_clamped_s);
      end
   end

   // Next-state logic of the block sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (count_clamped_s == {TCW{1'b0}}) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_FETCH;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (imem.imem_ack) begin
               state_next_s = ST_DECODE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DECODE:  state_next_s = ST_REQUEST;
         ST_REQUEST: state_next_s = ST_WAIT;
         ST_WAIT: begin
            if (wait_hold_s) begin
               state_next_s = ST_WAIT;
            end else begin
               state_next_s = ST_EXECUTE;
            end
         end
         ST_EXECUTE: state_next_s = ST_UPDATE;
         ST_UPDATE: begin
            if (is_ret) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_FETCH;
            end
         end
         ST_DONE:    state_next_s = ST_DONE;
         default:    state_next_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Block context, fetch handshake, pc, status outputs and busy counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         block_id_r      <= {BLOCK_ID_BITS{1'b0}};
         thread_enable_r <= {THREADS_PER_BLOCK{1'b0}};
         pc_r            <= {PC_BITS{1'b0}};
         instr_r         <= {INSTR_BITS{1'b0}};
         instr_valid_r   <= 1'b0;
         imem_req_r      <= 1'b0;
         busy_cycles_r   <= {BUSY_BITS{1'b0}};
         done_r          <= 1'b0;
      end else begin
         // Request is high exactly while the sequencer sits in FETCH.
         imem_req_r    <= (state_next_s == ST_FETCH);
         instr_valid_r <= (state_r == ST_FETCH) && imem.imem_ack;
         done_r        <= (state_next_s == ST_DONE);
         if (busy_active_s && (busy_cycles_r != 16'hFFFF)) begin
            busy_cycles_r <= busy_cycles_r + 16'd1;
         end
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  block_id_r      <= block_id_in;
                  thread_enable_r <= enable_mask_s;
                  pc_r            <= {PC_BITS{1'b0}};
               end
            end
            ST_FETCH: begin
               if (imem.imem_ack) begin
                  instr_r <= imem.imem_data;
               end
            end
            ST_UPDATE: begin
               if (!is_ret) begin
                  pc_r <= next_pc_t0_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign imem.imem_req  = imem_req_r;
   assign imem.imem_addr = pc_r;
   assign block_id       = block_id_r;
   assign thread_enable  = thread_enable_r;
   assign instr          = instr_r;
   assign instr_valid    = instr_valid_r;
   assign pc             = pc_r;
   assign core_state     = state_r;
   assign busy_cycles    = busy_cycles_r;
   assign done           = done_r;

endmodule

// File: tb/tb_core_block_ctrl.sv
// ----------------------------------------------------------------------------
// tb_core_block_ctrl
//   Self-checking bench for core_block_ctrl. Small programs ending in RET are
//   served from a bench-side instruction memory; expected timing, masks and
//   counters come from a cycle-budget model of the block protocol.
// ----------------------------------------------------------------------------
module tb_core_block_ctrl;
   import gpgpu_int8_pkg::*;

   localparam int T = THREADS_PER_BLOCK;
   localparam logic [INSTR_BITS-1:0] RET_OP = 16'hF000;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      start;
   logic [BLOCK_ID_BITS-1:0]  block_id_in;
   logic [TCW-1:0]            thread_count_in;
   logic [BLOCK_ID_BITS-1:0]  block_id;
   logic [T-1:0]              thread_enable;
   logic [INSTR_BITS-1:0]     instr;
   logic                      instr_valid;
   logic                      is_ret;
   logic [T-1:0]              mem_pending;
   logic [T*PC_BITS-1:0]      next_pc;
   logic [PC_BITS-1:0]        pc;
   logic [2:0]                core_state;
   logic [BUSY_BITS-1:0]      busy_cycles;
   logic                      done;
   logic [PC_BITS-1:0]        junk_pc;

   core_block_ctrl_if imem_bus();

   core_block_ctrl dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .block_id_in     (block_id_in),
      .thread_count_in (thread_count_in),
      .block_id        (block_id),
      .thread_enable   (thread_enable),
      .imem            (imem_bus),
      .instr           (instr),
      .instr_valid     (instr_valid),
      .is_ret          (is_ret),
      .mem_pending     (mem_pending),
      .next_pc         (next_pc),
      .pc              (pc),
      .core_state      (core_state),
      .busy_cycles     (busy_cycles),
      .done            (done)
   );

   always #5 clk = ~clk;

   // Decoder stand-in; threads other than 0 report unrelated next pcs.
   assign is_ret  = (instr == RET_OP);
   assign next_pc = {{(T-1){junk_pc}}, pc + 8'd1};

   int checks = 0;
   int errors = 0;

   logic [INSTR_BITS-1:0] prog [0:255];
   int m_done_cyc, m_pulses, m_wait_len, m_req_hi, m_bad_capture, m_done_drop;
   bit m_req_ever;
   int m_addr_q[$];

   // ---------------- reference model ----------------
   function automatic logic [T-1:0] exp_mask(input int cnt);
      int c;
      logic [31:0] m;
      c = (cnt > T) ? T : cnt;
      m = (32'd1 << c) - 32'd1;
      return m[T-1:0];
   endfunction

   // Edges from the start-sampling edge until done is visible.
   function automatic int exp_cycles(input int cnt, input int n, input int dly,
                                     input logic [T-1:0] pmask, input int pcyc);
      int extra;
      if (exp_mask(cnt) == '0) return 1;
      extra = ((pmask & exp_mask(cnt)) != '0) ? pcyc : 0;
      return 1 + n * (6 + dly + extra);
   endfunction

   // ---------------- block driver ----------------
   task automatic run_block(input int bid, input int cnt, input int n_instr,
                            input int ack_dly, input logic [T-1:0] pmask,
                            input int pcyc, input bit spurious,
                            input bit stop_in_wait, input int budget);
      int req_cnt;
      int pend_left;
      bit req_prev;
      bit fetch_ack_prev;
      logic [INSTR_BITS-1:0] instr_prev;
      reset = 1'b1;
      start = 1'b0;
      imem_bus.imem_ack  = 1'b0;
      imem_bus.imem_data = '0;
      mem_pending = '0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < n_instr - 1; i++) prog[i] = 16'($urandom_range(0, 32'hEFFF));
      prog[n_instr-1] = RET_OP;
      m_done_cyc = -1; m_pulses = 0; m_wait_len = 0; m_req_hi = 0;
      m_bad_capture = 0; m_done_drop = 0; m_req_ever = 1'b0;
      m_addr_q.delete();
      block_id_in     = bid[BLOCK_ID_BITS-1:0];
      thread_count_in = cnt[TCW-1:0];
      start = 1'b1;
      req_cnt = 0; pend_left = -1; req_prev = 1'b0; instr_prev = instr;
      for (int cyc = 1; cyc <= budget; cyc++) begin
         @(posedge clk); @(negedge clk);
         start = 1'b0;
         fetch_ack_prev = imem_bus.imem_ack && req_prev;
         if (instr !== instr_prev && !fetch_ack_prev) m_bad_capture++;
         instr_prev = instr;
         req_prev   = imem_bus.imem_req;
         if (m_done_cyc >= 0 && done !== 1'b1) m_done_drop++;
         if (done === 1'b1 && m_done_cyc < 0) m_done_cyc = cyc;
         if (instr_valid === 1'b1) m_pulses++;
         if (core_state == 3'd4) m_wait_len++;
         if (stop_in_wait && core_state == 3'd4) break;
         junk_pc = 8'($urandom);
         if (imem_bus.imem_req === 1'b1) begin
            m_req_ever = 1'b1;
            m_req_hi++;
            if (req_cnt == ack_dly) begin
               imem_bus.imem_ack  = 1'b1;
               imem_bus.imem_data = prog[imem_bus.imem_addr];
               m_addr_q.push_back(int'(imem_bus.imem_addr));
               req_cnt = 0;
            end else begin
               imem_bus.imem_ack  = 1'b0;
               imem_bus.imem_data = 16'($urandom);
               req_cnt++;
            end
         end else begin
            imem_bus.imem_ack  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_bus.imem_data = 16'($urandom);
         end
         if (core_state != 3'd4) pend_left = -1;
         else if (pend_left < 0) pend_left = pcyc;
         if (pend_left > 0) begin
            mem_pending = pmask;
            pend_left--;
         end else begin
            mem_pending = '0;
         end
         if (m_done_cyc >= 0 && cyc >= m_done_cyc + 3) break;
      end
      imem_bus.imem_ack = 1'b0;
      mem_pending = '0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset = 1'b1; start = 1'b1;
      block_id_in = 8'h5A; thread_count_in = 5'd7;
      imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 16'h1234; mem_pending = '0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++;
      if (core_state !== 3'd0 || done !== 1'b0 || imem_bus.imem_req !== 1'b0 ||
          pc !== 8'd0 || block_id !== 8'd0 || thread_enable !== 16'h0000 ||
          instr !== 16'h0000 || instr_valid !== 1'b0 || busy_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: state=%0d done=%b req=%b pc=%0d bid=%0d en=%h instr=%h iv=%b busy=%0d, required all zero",
                  core_state, done, imem_bus.imem_req, pc, block_id, thread_enable, instr, instr_valid, busy_cycles);
      end
      start = 1'b0; imem_bus.imem_ack = 1'b0;
   endtask

   task automatic test_single_ret;
      int ec;
      ec = exp_cycles(16, 1, 0, '0, 0);
      run_block(3, 16, 1, 0, '0, 0, 1'b0, 1'b0, ec + 10);
      checks++;
      if (block_id !== 8'd3) begin errors++; $display("FAIL single_block_id: got %0d required 3", block_id); end
      checks++;
      if (thread_enable !== 16'hFFFF) begin errors++; $display("FAIL single_enable: got %h required ffff", thread_enable); end
      checks++;
      if (m_done_cyc != 7 || ec != 7) begin errors++; $display("FAIL single_done_edge: got %0d required 7", m_done_cyc); end
      checks++;
      if (busy_cycles !== 16'd6) begin errors++; $display("FAIL single_busy: got %0d required 6", busy_cycles); end
      checks++;
      if (m_done_drop != 0 || core_state !== 3'd7) begin
         errors++; $display("FAIL single_done_hold: drops=%0d state=%0d required 0 drops state 7", m_done_drop, core_state);
      end
   endtask

   task automatic test_thread_mask;
      int cnts[6];
      int ec;
      cnts = '{5, 20, 0, 31, 1, 0};
      cnts[5] = $urandom_range(2, 15);
      foreach (cnts[k]) begin
         ec = exp_cycles(cnts[k], 1, 0, '0, 0);
         run_block($urandom_range(0, 255), cnts[k], 1, 0, '0, 0, 1'b1, 1'b0, ec + 10);
         checks++;
         if (thread_enable !== exp_mask(cnts[k])) begin
            errors++; $display("FAIL mask_count%0d: got %h required %h", cnts[k], thread_enable, exp_mask(cnts[k]));
         end
         checks++;
         if (m_done_cyc != ec) begin
            errors++; $display("FAIL mask_done_count%0d: got %0d required %0d", cnts[k], m_done_cyc, ec);
         end
         checks++;
         if (m_req_ever != (cnts[k] != 0)) begin
            errors++; $display("FAIL mask_req_count%0d: req_seen=%0d required %0d", cnts[k], m_req_ever, cnts[k] != 0);
         end
      end
   endtask

   task automatic test_program;
      int n, dly, ec;
      for (int it = 0; it < 4; it++) begin
         n   = (it == 0) ? 3 : $urandom_range(2, 6);
         dly = (it == 0) ? 0 : $urandom_range(0, 2);
         ec  = exp_cycles(16, n, dly, '0, 0);
         run_block(it, $urandom_range(1, 16), n, dly, '0, 0, 1'b1, 1'b0, ec + 10);
         checks++;
         if (m_addr_q.size() != n) begin
            errors++; $display("FAIL prog_fetch_count it%0d: got %0d required %0d", it, m_addr_q.size(), n);
         end else begin
            foreach (m_addr_q[i]) begin
               checks++;
               if (m_addr_q[i] != i) begin
                  errors++; $display("FAIL prog_addr it%0d idx%0d: got %0d required %0d", it, i, m_addr_q[i], i);
               end
            end
         end
         checks++;
         if (m_pulses != n) begin errors++; $display("FAIL prog_pulses it%0d: got %0d required %0d", it, m_pulses, n); end
         checks++;
         if (m_done_cyc != ec) begin errors++; $display("FAIL prog_done it%0d: got %0d required %0d", it, m_done_cyc, ec); end
         checks++;
         if (busy_cycles !== 16'(ec - 1)) begin
            errors++; $display("FAIL prog_busy it%0d: got %0d required %0d", it, busy_cycles, ec - 1);
         end
         checks++;
         if (m_bad_capture != 0) begin errors++; $display("FAIL prog_capture it%0d: %0d stray instr updates, required 0", it, m_bad_capture); end
      end
   endtask

   task automatic test_wait;
      logic [T-1:0] pm;
      int cnt, pcyc, ec, ew;
      for (int it = 0; it < 4; it++) begin
         case (it)
            0: begin pm = 16'h0004; cnt = 16; pcyc = 4; end
            1: begin pm = 16'h0200; cnt = 5;  pcyc = 4; end
            default: begin pm = 16'($urandom); cnt = $urandom_range(1, 16); pcyc = $urandom_range(1, 6); end
         endcase
         ec = exp_cycles(cnt, 1, 0, pm, pcyc);
         ew = ec - 6;
         run_block(7, cnt, 1, 0, pm, pcyc, 1'b0, 1'b0, ec + 10);
         checks++;
         if (m_wait_len != ew) begin errors++; $display("FAIL wait_len it%0d: got %0d required %0d", it, m_wait_len, ew); end
         checks++;
         if (m_done_cyc != ec) begin errors++; $display("FAIL wait_done it%0d: got %0d required %0d", it, m_done_cyc, ec); end
      end
   endtask

   task automatic test_ack_delay;
      int ec;
      ec = exp_cycles(8, 1, 3, '0, 0);
      run_block(9, 8, 1, 3, '0, 0, 1'b0, 1'b0, ec + 10);
      checks++;
      if (m_req_hi != 4) begin errors++; $display("FAIL ack_req_cycles: got %0d required 4", m_req_hi); end
      checks++;
      if (m_bad_capture != 0 || instr !== RET_OP) begin
         errors++; $display("FAIL ack_capture: stray=%0d instr=%h required 0 and %h", m_bad_capture, instr, RET_OP);
      end
      checks++;
      if (m_done_cyc != ec) begin errors++; $display("FAIL ack_done: got %0d required %0d", m_done_cyc, ec); end
   endtask

   task automatic test_reset_midblock;
      int ec;
      run_block(4, 16, 2, 1, 16'h0001, 6, 1'b0, 1'b1, 40);
      checks++;
      if (core_state !== 3'd4) begin errors++; $display("FAIL midreset_reach_wait: state=%0d required 4", core_state); end
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (core_state !== 3'd0 || done !== 1'b0 || imem_bus.imem_req !== 1'b0 || instr !== 16'h0000) begin
         errors++; $display("FAIL midreset_state: state=%0d done=%b req=%b instr=%h required 0 0 0 0000",
                            core_state, done, imem_bus.imem_req, instr);
      end
      reset = 1'b0; start = 1'b0;
      imem_bus.imem_ack = 1'b1; imem_bus.imem_data = 16'hABCD;
      @(posedge clk); @(negedge clk);
      imem_bus.imem_ack = 1'b0;
      checks++;
      if (core_state !== 3'd0 || instr !== 16'h0000 || instr_valid !== 1'b0 || busy_cycles !== 16'd0) begin
         errors++; $display("FAIL midreset_late_ack: state=%0d instr=%h iv=%b busy=%0d required 0 0000 0 0",
                            core_state, instr, instr_valid, busy_cycles);
      end
      ec = exp_cycles(12, 2, 0, '0, 0);
      run_block(11, 12, 2, 0, '0, 0, 1'b0, 1'b0, ec + 10);
      checks++;
      if (m_done_cyc != ec || block_id !== 8'd11) begin
         errors++; $display("FAIL midreset_rerun: done_edge=%0d bid=%0d required %0d 11", m_done_cyc, block_id, ec);
      end
   endtask

   task automatic test_random;
      int cnt, n, dly, pcyc, ec;
      logic [T-1:0] pm;
      for (int it = 0; it < 6; it++) begin
         cnt = $urandom_range(0, 31); n = $urandom_range(1, 4);
         dly = $urandom_range(0, 3); pcyc = $urandom_range(0, 3);
         pm = 16'($urandom);
         ec = exp_cycles(cnt, n, dly, pm, pcyc);
         run_block($urandom_range(0, 255), cnt, n, dly, pm, pcyc, 1'b1, 1'b0, ec + 10);
         checks++;
         if (m_done_cyc != ec || busy_cycles !== 16'(ec - 1) || thread_enable !== exp_mask(cnt)) begin
            errors++; $display("FAIL random it%0d: done_edge=%0d busy=%0d en=%h required %0d %0d %h",
                               it, m_done_cyc, busy_cycles, thread_enable, ec, ec - 1, exp_mask(cnt));
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; block_id_in = '0; thread_count_in = '0;
      mem_pending = '0; junk_pc = '0;
      imem_bus.imem_ack = 1'b0; imem_bus.imem_data = '0;
      test_reset();
      test_single_ret();
      test_thread_mask();
      test_program();
      test_wait();
      test_ack_delay();
      test_reset_midblock();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
